// File: rtl/dla_demux_dest_sequencer_if.sv
// Handshake bundle between the config network / feature stream and the demux
// destination sequencer: command, input data and tagged output streams.
interface dla_demux_dest_sequencer_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int DEST_W      = 2,
    parameter int COUNT_WIDTH = 24
);
    logic                   i_cfg_valid;
    logic                   o_cfg_ready;
    logic [DEST_W-1:0]      i_cfg_dest;
    logic [COUNT_WIDTH-1:0] i_cfg_count;
    logic                   i_in_valid;
    logic                   o_in_ready;
    logic [DATA_WIDTH-1:0]  i_in_data;
    logic                   o_out_valid;
    logic                   i_out_ready;
    logic [DATA_WIDTH-1:0]  o_out_data;
    logic [DEST_W-1:0]      o_out_dest;
    logic                   o_out_last;

    modport slave (
        input  i_cfg_valid, i_cfg_dest, i_cfg_count, i_in_valid, i_in_data, i_out_ready,
        output o_cfg_ready, o_in_ready, o_out_valid, o_out_data, o_out_dest, o_out_last
    );

    modport master (
        output i_cfg_valid, i_cfg_dest, i_cfg_count, i_in_valid, i_in_data, i_out_ready,
        input  o_cfg_ready, o_in_ready, o_out_valid, o_out_data, o_out_dest, o_out_last
    );
endinterface

// File: rtl/dla_demux_dest_sequencer.sv
// Tags each feature-data word with a destination and end-of-transfer marker,
// driven by queued (dest, count) commands; output is a registered valid/ready stream.
module dla_demux_dest_sequencer #(
    parameter int DATA_WIDTH  = 256,
    parameter int NUM_DEST    = 4,
    parameter int COUNT_WIDTH = 24,
    parameter int CFG_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          i_sclr,
    dla_demux_dest_sequencer_if.slave     bus,
    output logic                          o_busy,
    output logic                          o_err
);
    localparam int DEST_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam int PTR_W  = $clog2(CFG_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_V    = (PTR_W + 1)'(CFG_DEPTH);
    localparam logic [DEST_W:0] NUM_DEST_V = (DEST_W + 1)'(NUM_DEST);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM} state_t;

    logic [DEST_W-1:0]      fifo_dest_q  [CFG_DEPTH];
    logic [COUNT_WIDTH-1:0] fifo_count_q [CFG_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         occ_q, occ_d;
    logic                   cfg_ready_q, cfg_ready_d;
    state_t                 state_q, state_d;
    logic [DEST_W-1:0]      dest_q, dest_d;
    logic                   drop_q, drop_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [DEST_W-1:0]      out_dest_q, out_dest_d;
    logic                   out_last_q, out_last_d;
    logic                   err_q, err_d;

    logic                   push, pop, accept, out_fire, pending_after;
    logic [DEST_W-1:0]      head_dest;
    logic [COUNT_WIDTH-1:0] head_count;

    assign head_dest  = fifo_dest_q[rd_ptr_q];
    assign head_count = fifo_count_q[rd_ptr_q];

    assign bus.o_cfg_ready = cfg_ready_q && !i_sclr;
    assign bus.o_in_ready  = !i_sclr && (state_q == ST_STREAM) &&
                             (drop_q || !out_valid_q || bus.i_out_ready);

    assign push     = bus.i_cfg_valid && bus.o_cfg_ready;
    assign pop      = (state_q == ST_LOAD);
    assign accept   = bus.i_in_valid && bus.o_in_ready;
    assign out_fire = out_valid_q && bus.i_out_ready;

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d         = occ_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        cfg_ready_d   = (occ_d != DEPTH_V);
        // Commands still queued after this cycle's pop and push
        pending_after = (occ_d != '0);

        state_d     = state_q;
        dest_d      = dest_q;
        drop_d      = drop_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_dest_d  = out_dest_q;
        out_last_d  = out_last_q;

        if (accept && !drop_q) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.i_in_data;
            out_dest_d  = dest_q;
            out_last_d  = (remaining_q == COUNT_WIDTH'(1));
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (occ_q != '0) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                dest_d = head_dest;
                drop_d = ({1'b0, head_dest} >= NUM_DEST_V);
                if (drop_d) err_d = 1'b1;
                if (head_count == '0) begin
                    state_d = pending_after ? ST_LOAD : ST_IDLE;
                end else begin
                    remaining_d = head_count;
                    state_d     = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    if (remaining_q == COUNT_WIDTH'(1))
                        state_d = pending_after ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            cfg_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
            dest_q      <= '0;
            drop_q      <= 1'b0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            cfg_ready_q <= cfg_ready_d;
            state_q     <= state_d;
            dest_q      <= dest_d;
            drop_q      <= drop_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_dest_q  <= out_dest_d;
            out_last_q  <= out_last_d;
        end
        if (push) begin
            fifo_dest_q[wr_ptr_q]  <= bus.i_cfg_dest;
            fifo_count_q[wr_ptr_q] <= bus.i_cfg_count;
        end
    end

    assign bus.o_out_valid = out_valid_q;
    assign bus.o_out_data  = out_data_q;
    assign bus.o_out_dest  = out_dest_q;
    assign bus.o_out_last  = out_last_q;
    assign o_err           = err_q;
    assign o_busy          = (state_q != ST_IDLE) || (occ_q != '0) || out_valid_q;
endmodule
